// File: rtl/cla_adder_arbiter_pkg.sv
// rtl/cla_adder_arbiter_pkg.sv - shared defaults and types for the arbitrated CLA adder
//
// Purpose: default widths and requester count, plus the result-stage state type,
// shared by the arbiter top and the adder.
// Ports: none (package).
package cla_adder_arbiter_pkg;

  localparam int DEF_BUS_WIDTH       = 32;
  localparam int DEF_CLA_BLOCK_WIDTH = 4;
  localparam int DEF_NUM_REQ         = 4;

  // Result stage: EMPTY = nothing held, FULL = result presented on rsp_*.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/carry_look_ahead_adder.sv
// rtl/carry_look_ahead_adder.sv - block carry-look-ahead adder/subtractor, purely combinational
//
// Purpose: WIDTH-bit add or two's-complement subtract (in1 + ~in2 + 1), modulo 2^WIDTH.
// Ports:
//   in1_i  [WIDTH-1:0]  operand 1
//   in2_i  [WIDTH-1:0]  operand 2
//   sub_i               0 = add, 1 = subtract (in1 - in2)
//   sum_o  [WIDTH-1:0]  result, carry-out discarded
module carry_look_ahead_adder #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK_WIDTH;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  // Subtract inverts operand 2 and injects the +1 through the carry-in.
  assign b_eff = in2_i ^ {WIDTH{sub_i}};
  assign g     = in1_i & b_eff;
  assign p     = in1_i ^ b_eff;

  // Inside a block every carry is a flat look-ahead expression of that block's
  // g/p and the block carry-in; block carry-ins ripple from block to block.
  always_comb begin
    logic gen_acc;
    logic prop_acc;
    c        = '0;
    gen_acc  = 1'b0;
    prop_acc = 1'b0;
    c[0]     = sub_i;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      for (int j = 0; j < BLOCK_WIDTH; j++) begin
        gen_acc  = 1'b0;
        prop_acc = 1'b1;
        for (int k = j; k >= 0; k--) begin
          gen_acc  = gen_acc | (prop_acc & g[b*BLOCK_WIDTH + k]);
          prop_acc = prop_acc & p[b*BLOCK_WIDTH + k];
        end
        c[b*BLOCK_WIDTH + j + 1] = gen_acc | (prop_acc & c[b*BLOCK_WIDTH]);
      end
    end
  end

  assign sum_o = p ^ c[WIDTH-1:0];

endmodule

// File: rtl/cla_adder_arbiter.sv
// rtl/cla_adder_arbiter.sv - round-robin shared CLA adder with one-entry result stage
//
// Purpose: NUM_REQ requesters share one carry_look_ahead_adder; a rotating-priority
// arbiter picks one request per cycle and its result is registered (1-cycle latency).
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/req_ready [NUM_REQ]   per-requester handshake (ready is one-hot or zero)
//   req_sub [NUM_REQ]               0 = add, 1 = in1 - in2
//   req_in1/req_in2                 packed operands, requester k at [k*BUS_WIDTH +: BUS_WIDTH]
//   rsp_valid/rsp_ready             result handshake
//   rsp_id, rsp_data                owner index and result
//   busy                            mirrors rsp_valid
module cla_adder_arbiter
  import cla_adder_arbiter_pkg::*;
#(
  parameter int  BUS_WIDTH       = DEF_BUS_WIDTH,
  parameter int  CLA_BLOCK_WIDTH = DEF_CLA_BLOCK_WIDTH,
  parameter int  NUM_REQ         = DEF_NUM_REQ,
  localparam int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_sub,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [BUS_WIDTH-1:0]         rsp_data,
  output logic                         busy
);

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   rr_ptr_d;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [BUS_WIDTH-1:0]  rsp_data_q;

  logic                  found;
  logic [ID_WIDTH-1:0]   win;
  logic                  can_accept;
  logic                  accept;
  logic [BUS_WIDTH-1:0]  in1_arr [NUM_REQ];
  logic [BUS_WIDTH-1:0]  in2_arr [NUM_REQ];
  logic [BUS_WIDTH-1:0]  sum;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign in1_arr[k] = req_in1[k*BUS_WIDTH +: BUS_WIDTH];
    assign in2_arr[k] = req_in2[k*BUS_WIDTH +: BUS_WIDTH];
  end

  // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int                  idx_int;
    logic [ID_WIDTH-1:0] idx;
    found   = 1'b0;
    win     = '0;
    idx_int = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_int = (int'(rr_ptr_q) + i) % NUM_REQ;
      idx     = ID_WIDTH'(idx_int);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A held result that is being drained frees the stage in the same cycle.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign accept     = found && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign rr_ptr_d = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  carry_look_ahead_adder #(
    .WIDTH       (BUS_WIDTH),
    .BLOCK_WIDTH (CLA_BLOCK_WIDTH)
  ) u_cla (
    .in1_i (in1_arr[win]),
    .in2_i (in2_arr[win]),
    .sub_i (req_sub[win]),
    .sum_o (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        state_q    <= ST_FULL;
        rr_ptr_q   <= rr_ptr_d;
        rsp_id_q   <= win;
        rsp_data_q <= sum;
      end else if ((state_q == ST_FULL) && rsp_ready) begin
        // Drain only: id/data keep their last values.
        state_q <= ST_EMPTY;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = rsp_valid;

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// tb/tb_cla_adder_arbiter.sv - self-checking bench for cla_adder_arbiter
module tb_cla_adder_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_sub = '0;
  logic [NR*W-1:0] req_in1 = '0;
  logic [NR*W-1:0] req_in2 = '0;
  logic            rsp_ready = 1'b0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  bit   m_full = 1'b0;
  int   m_ptr = 0;

  cla_adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model + scoreboard: push at accept, pop when the result is consumed.
  always @(negedge clk) begin
    bit           fnd;
    int           w;
    int           idx;
    logic [NR-1:0] exp_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      fnd = 1'b0;
      w   = 0;
      for (int i = 0; i < NR; i++) begin
        idx = (m_ptr + i) % NR;
        if (!fnd && req_valid[idx]) begin
          fnd = 1'b1;
          w   = idx;
        end
      end
      exp_ready = '0;
      if (fnd && (!m_full || rsp_ready)) exp_ready[w] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL sb_req_ready got=%b want=%b t=%0t", req_ready, exp_ready, $time);
      end
      checks++;
      if (rsp_valid !== m_full || busy !== m_full) begin
        failures++;
        $display("FAIL sb_rsp_valid got=%b busy=%b want=%b t=%0t", rsp_valid, busy, m_full, $time);
      end
      if (m_full && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got=empty want=entry t=%0t", $time);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL sb_result got=%0d/%h want=%0d/%h t=%0t", rsp_id, rsp_data, e.id, e.data, $time);
          end
        end
      end
      if (exp_ready != '0) begin
        a = req_in1[w*W +: W];
        b = req_in2[w*W +: W];
        e.id   = 2'(w);
        e.data = req_sub[w] ? (a - b) : (a + b);
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (w + 1) % NR;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic issue(input int k, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
    bit granted;
    granted = 1'b0;
    req_in1[k*W +: W] = a;
    req_in2[k*W +: W] = b;
    req_sub[k]   = sub;
    req_valid[k] = 1'b1;
    for (int n = 0; n < 50 && !granted; n++) begin
      @(negedge clk);
      granted = req_ready[k];
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    checks++;
    if (!granted) begin
      failures++;
      $display("FAIL issue_grant req=%0d got=0 want=1", k);
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got=%b/%b/%b/%0d/%h want=0000/0/0/0/0", req_ready, rsp_valid, busy, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    issue(0, 1'b0, 32'd5, 32'd7);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd12) begin
      failures++;
      $display("FAIL single_add got=%b/%0d/%0d want=1/0/12", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_wrap();
    issue(2, 1'b1, 32'd10, 32'd3);
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd2 || rsp_data !== 32'd7) begin
      failures++;
      $display("FAIL sub_10_3 got=%0d/%h want=2/00000007", rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    issue(1, 1'b1, 32'h0000_0000, 32'd1);
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd1 || rsp_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sub_wrap got=%0d/%h want=1/ffffffff", rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    issue(3, 1'b0, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd3 || rsp_data !== 32'h0000_0000) begin
      failures++;
      $display("FAIL add_wrap got=%0d/%h want=3/00000000", rsp_id, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < NR; k++) begin
      req_in1[k*W +: W] = 32'(100 * k + 1);
      req_in2[k*W +: W] = 32'(k + 17);
      req_sub[k] = k[0];
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_seq[i])) begin
        failures++;
        $display("FAIL rr_seq[%0d] got=%b/%0d want=1/%0d", i, rsp_valid, rsp_id, exp_seq[i]);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    issue(1, 1'b0, 32'd1000, 32'd234);
    rsp_ready = 1'b0;
    req_in1[3*W +: W] = 32'd50;
    req_in2[3*W +: W] = 32'd80;
    req_sub[3]   = 1'b1;
    req_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'd1234 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%0d/%b want=1/1/1234/0000", i, rsp_valid, rsp_id, rsp_data, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_same_edge got=%b want=1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'hFFFF_FFE2) begin
      failures++;
      $display("FAIL bp_follow got=%b/%0d/%h want=1/3/ffffffe2", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pointer_skip();
    issue(3, 1'b0, 32'd3, 32'd4);
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd3) begin
      failures++;
      $display("FAIL skip_grant3 got=%0d want=3", rsp_id);
    end
    @(posedge clk); #1;
    issue(1, 1'b0, 32'd9, 32'd9);
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd1 || rsp_data !== 32'd18) begin
      failures++;
      $display("FAIL skip_grant1 got=%0d/%0d want=1/18", rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    // Pointer should now sit at 2: requester 2 beats requester 0.
    req_in1[0 +: W] = 32'd40; req_in2[0 +: W] = 32'd2; req_sub[0] = 1'b1;
    req_in1[2*W +: W] = 32'd6; req_in2[2*W +: W] = 32'd6; req_sub[2] = 1'b0;
    req_valid = 4'b0101;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL skip_ptr2 got=%b want=0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd2 || rsp_data !== 32'd12 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL skip_then0 got=%0d/%0d/%b want=2/12/0001", rsp_id, rsp_data, req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd0 || rsp_data !== 32'd38) begin
      failures++;
      $display("FAIL skip_last got=%0d/%0d want=0/38", rsp_id, rsp_data);
    end
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b0;
    issue(1, 1'b0, 32'd7, 32'd8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0) begin
      failures++;
      $display("FAIL async_rst got=%b/%b/%0d/%0d want=0/0/0/0", rsp_valid, busy, rsp_id, rsp_data);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    issue(2, 1'b1, 32'd20, 32'd5);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd15) begin
      failures++;
      $display("FAIL post_rst got=%b/%0d/%0d want=1/2/15", rsp_valid, rsp_id, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_async_reset();
    rsp_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
